// File: rtl/mips_multicycle.sv
// Multicycle MIPS core: a controller FSM sequences a shared IR/MDR/A/B/ALUOut datapath
// over one unified request/ready memory port.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic [DATA_W-1:0] memaddr,
    output logic              memread,
    output logic              memwrite,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    input  logic              memready,
    output logic [DATA_W-1:0] pc,
    output logic              retire
);

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned OP_W     = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FN_ADD = 6'h20;
    localparam logic [OP_W-1:0] FN_SUB = 6'h22;
    localparam logic [OP_W-1:0] FN_AND = 6'h24;
    localparam logic [OP_W-1:0] FN_OR  = 6'h25;
    localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

    if (DATA_W != 32) begin : g_width_check
        $error("mips_multicycle: only DATA_W = 32 is supported");
    end

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_ADDIEX,
        S_ADDIWB,
        S_BRANCH,
        S_JUMP
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] pc_q, ir, mdr, a_q, b_q, alu_out;
    logic [DATA_W-1:0] rf [NUM_REGS];

    logic [OP_W-1:0]   op, funct;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [DATA_W-1:0] imm_se;

    logic              ir_we, pc_we, mdr_we, ab_we, alu_we, rf_we;
    logic [DATA_W-1:0] pc_nxt, alu_nxt, rf_wd, alu_r;
    logic [REG_AW-1:0] rf_wa;
    logic              funct_ok;

    assign op     = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign imm_se = {{(DATA_W-16){ir[15]}}, ir[15:0]};

    assign pc = reset ? DATA_W'(RESET_PC) : pc_q;

    // R-type ALU; unsupported funct codes are caught in DECODE and never reach EXEC
    always_comb begin
        alu_r    = '0;
        funct_ok = 1'b1;
        case (funct)
            FN_ADD:  alu_r = a_q + b_q;
            FN_SUB:  alu_r = a_q - b_q;
            FN_AND:  alu_r = a_q & b_q;
            FN_OR:   alu_r = a_q | b_q;
            FN_SLT:  alu_r = DATA_W'($signed(a_q) < $signed(b_q));
            default: funct_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Controller: next state, datapath enables and memory-port outputs
    always_comb begin
        state_nxt = state;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        mdr_we    = 1'b0;
        ab_we     = 1'b0;
        alu_we    = 1'b0;
        rf_we     = 1'b0;
        pc_nxt    = pc_q + DATA_W'(4);
        alu_nxt   = a_q + imm_se;
        rf_wa     = rt;
        rf_wd     = alu_out;
        memread   = 1'b0;
        memwrite  = 1'b0;
        memaddr   = pc_q;
        writedata = b_q;
        retire    = 1'b0;

        case (state)
            S_FETCH: begin
                memread = 1'b1;
                if (memready) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                ab_we   = 1'b1;
                alu_we  = 1'b1;
                alu_nxt = pc_q + (imm_se << 2);
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            state_nxt = S_EXEC;
                        end else begin
                            retire    = 1'b1;
                            state_nxt = S_FETCH;
                        end
                    end
                    default: begin
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_we    = 1'b1;
                state_nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memread = 1'b1;
                memaddr = alu_out;
                if (memready) begin
                    mdr_we    = 1'b1;
                    state_nxt = S_MEMWB;
                end
            end
            S_MEMWB: begin
                rf_we     = 1'b1;
                rf_wd     = mdr;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                memaddr  = alu_out;
                if (memready) begin
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_we    = 1'b1;
                alu_nxt   = alu_r;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we     = 1'b1;
                rf_wa     = rd;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ADDIEX: begin
                alu_we    = 1'b1;
                state_nxt = S_ADDIWB;
            end
            S_ADDIWB: begin
                rf_we     = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                if (a_q == b_q) begin
                    pc_we  = 1'b1;
                    pc_nxt = alu_out;
                end
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JUMP: begin
                pc_we     = 1'b1;
                pc_nxt    = {pc_q[DATA_W-1:DATA_W-4], ir[25:0], 2'b00};
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase

        // Reset silences the port in the same cycle, dropping any pending store
        if (reset) begin
            memread   = 1'b0;
            memwrite  = 1'b0;
            retire    = 1'b0;
            memaddr   = DATA_W'(RESET_PC);
            writedata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= DATA_W'(RESET_PC);
            ir      <= '0;
            mdr     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_out <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (pc_we)  pc_q    <= pc_nxt;
            if (ir_we)  ir      <= readdata;
            if (mdr_we) mdr     <= readdata;
            if (alu_we) alu_out <= alu_nxt;
            if (ab_we) begin
                a_q <= rf[rs];
                b_q <= rf[rt];
            end
            // $0 is never written, so it always reads back as zero
            if (rf_we && (rf_wa != '0)) begin
                rf[rf_wa] <= rf_wd;
            end
        end
    end

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: bench-side unified memory with programmable data wait states,
// scoreboards for retire latency / next pc and for store traffic.
`timescale 1ns/1ps
module tb_mips_multicycle;

    localparam logic [31:0] RST_PC    = 32'h0000_0100;
    localparam int unsigned MEM_WORDS = 1024;

    localparam logic [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
    localparam logic [5:0] FN_NOR = 6'h27;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] memaddr, writedata, readdata, pc;
    logic        memread, memwrite, memready, retire;

    always #5 clk = ~clk;

    mips_multicycle #(.RESET_PC(RST_PC), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .memaddr   (memaddr),
        .memread   (memread),
        .memwrite  (memwrite),
        .writedata (writedata),
        .readdata  (readdata),
        .memready  (memready),
        .pc        (pc),
        .retire    (retire)
    );

    typedef struct { int unsigned cyc; logic [31:0] next_pc; } ret_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

    ret_t        ret_q[$];
    wr_t         wr_q[$];
    logic [31:0] mem [MEM_WORDS];

    int          checks   = 0;
    int          failures = 0;
    int unsigned data_wait, wcnt, cyc_cnt;
    bit          busy, pc_chk, prev_wait, snap_rd, snap_wr;
    logic [31:0] exp_pc, snap_addr, snap_wd, ip;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int target);
        return {OP_J, 26'(target)};
    endfunction

    task automatic put_at(input logic [31:0] addr, input logic [31:0] instr);
        mem[addr[11:2]] = instr;
    endtask

    task automatic exp_ret(input int unsigned cyc, input logic [31:0] npc);
        ret_t r;
        r.cyc = cyc; r.next_pc = npc;
        ret_q.push_back(r);
    endtask

    task automatic exp_wr(input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr; w.data = data;
        wr_q.push_back(w);
    endtask

    // Straight-line instruction: falls through to ip+4
    task automatic lin(input logic [31:0] instr, input int unsigned cyc);
        put_at(ip, instr);
        exp_ret(cyc, ip + 32'd4);
        ip = ip + 32'd4;
    endtask

    // Memory responder; accesses below RST_PC are data and see data_wait wait states
    task automatic mem_model();
        if (memread || memwrite) begin
            if (!busy) begin
                busy = 1'b1;
                wcnt = (memaddr < RST_PC) ? data_wait : 0;
            end
            if (wcnt > 0) begin
                memready = 1'b0;
                wcnt--;
            end else begin
                memready = 1'b1;
                busy     = 1'b0;
            end
        end else begin
            memready = 1'($urandom_range(0, 1));
            busy     = 1'b0;
        end
        readdata = (memread && memready) ? mem[memaddr[11:2]] : 32'hDEAD_BEEF;
    endtask

    task automatic monitor();
        ret_t r;
        wr_t  w;
        if (reset) return;
        cyc_cnt++;
        if (prev_wait) begin
            check("hold_addr", memaddr, snap_addr);
            check("hold_req", {30'b0, memread, memwrite}, {30'b0, snap_rd, snap_wr});
            if (snap_wr) check("hold_wdata", writedata, snap_wd);
        end
        prev_wait = (memread || memwrite) && !memready;
        snap_addr = memaddr; snap_wd = writedata; snap_rd = memread; snap_wr = memwrite;
        if (pc_chk) begin
            check("next_pc", pc, exp_pc);
            check("fetch_addr", memaddr, exp_pc);
            check("fetch_req", 32'(memread), 32'd1);
            pc_chk = 1'b0;
        end
        if (memwrite && memready) begin
            if (wr_q.size() == 0) begin
                check("extra_write", 32'(memwrite), 32'd0);
            end else begin
                w = wr_q.pop_front();
                check("st_addr", memaddr, w.addr);
                check("st_data", writedata, w.data);
            end
            mem[memaddr[11:2]] = writedata;
        end
        if (retire) begin
            if (ret_q.size() == 0) begin
                check("extra_retire", 32'(retire), 32'd0);
            end else begin
                r = ret_q.pop_front();
                check("cpi", 32'(cyc_cnt), 32'(r.cyc));
                exp_pc = r.next_pc;
                pc_chk = 1'b1;
            end
            cyc_cnt = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        mem_model();
    endtask

    task automatic check_reset_outputs();
        #1;
        check("rst_memread", 32'(memread), 32'd0);
        check("rst_memwrite", 32'(memwrite), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_memaddr", memaddr, RST_PC);
        check("rst_wdata", writedata, 32'd0);
        check("rst_pc", pc, RST_PC);
    endtask

    task automatic begin_section(input int unsigned dw);
        reset = 1'b1;
        busy  = 1'b0;
        check_reset_outputs();
        tick();
        tick();
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
        ret_q.delete();
        wr_q.delete();
        data_wait = dw;
        ip        = RST_PC;
    endtask

    task automatic start();
        reset     = 1'b0;
        busy      = 1'b0;
        cyc_cnt   = 0;
        pc_chk    = 1'b0;
        prev_wait = 1'b0;
        #1;
        mem_model();
        #1;
        check("first_fetch_req", 32'(memread), 32'd1);
        check("first_fetch_addr", memaddr, RST_PC);
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((ret_q.size() != 0 || wr_q.size() != 0 || pc_chk) && n < budget) begin
            tick();
            n++;
        end
        if (ret_q.size() != 0 || wr_q.size() != 0 || pc_chk) begin
            check("timeout_ret", 32'(ret_q.size()), 32'd0);
            check("timeout_wr", 32'(wr_q.size()), 32'd0);
            ret_q.delete();
            wr_q.delete();
            pc_chk = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog global time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        memready = 1'b0;
        readdata = 32'h0;
        repeat (2) @(posedge clk);

        // Reset and NOP stream: one fetch every 2 cycles
        begin_section(0);
        exp_ret(2, 32'h104); exp_ret(2, 32'h108); exp_ret(2, 32'h10C);
        start();
        run(100);

        // ALU program, results stored to data memory
        begin_section(0);
        lin(enc_i(OP_ADDI, 1, 0, 5), 4);
        lin(enc_i(OP_ADDI, 2, 0, -3), 4);
        lin(enc_r(FN_ADD, 3, 1, 2), 4);
        lin(enc_r(FN_SUB, 4, 2, 1), 4);
        lin(enc_r(FN_SLT, 5, 2, 1), 4);
        lin(enc_r(FN_SLT, 9, 1, 2), 4);
        lin(enc_r(FN_AND, 7, 1, 2), 4);
        lin(enc_r(FN_OR, 8, 1, 2), 4);
        lin(enc_i(OP_SW, 3, 0, 0), 4);  exp_wr(32'd0,  32'd2);
        lin(enc_i(OP_SW, 4, 0, 4), 4);  exp_wr(32'd4,  32'hFFFF_FFF8);
        lin(enc_i(OP_SW, 5, 0, 8), 4);  exp_wr(32'd8,  32'd1);
        lin(enc_i(OP_SW, 9, 0, 12), 4); exp_wr(32'd12, 32'd0);
        lin(enc_i(OP_SW, 7, 0, 16), 4); exp_wr(32'd16, 32'd5);
        lin(enc_i(OP_SW, 8, 0, 20), 4); exp_wr(32'd20, 32'hFFFF_FFFD);
        start();
        run(300);

        // Memory path with 3 wait states on every data access
        begin_section(3);
        lin(enc_i(OP_ADDI, 1, 0, 5), 4);
        lin(enc_i(OP_SW, 1, 0, 8), 7);  exp_wr(32'd8, 32'd5);
        lin(enc_i(OP_LW, 6, 0, 8), 8);
        lin(enc_i(OP_SW, 6, 0, 12), 7); exp_wr(32'd12, 32'd5);
        start();
        run(200);

        // Control flow: untaken beq, jumps, backward taken beq; 0x10C/0x118 are traps
        begin_section(0);
        put_at(32'h100, enc_i(OP_ADDI, 1, 0, 1));  exp_ret(4, 32'h104);
        put_at(32'h104, enc_i(OP_BEQ, 1, 0, 5));   exp_ret(3, 32'h108);
        put_at(32'h108, enc_j(32'h45));            exp_ret(3, 32'h114);
        put_at(32'h114, enc_i(OP_BEQ, 1, 1, -2));  exp_ret(3, 32'h110);
        put_at(32'h110, enc_j(32'h47));            exp_ret(3, 32'h11C);
        put_at(32'h11C, enc_i(OP_SW, 1, 0, 0));    exp_ret(4, 32'h120); exp_wr(32'd0, 32'd1);
        put_at(32'h10C, enc_i(OP_SW, 1, 0, 4));
        put_at(32'h118, enc_i(OP_SW, 1, 0, 8));
        start();
        run(200);

        // Self-loop jump at 0x100
        begin_section(0);
        put_at(32'h100, enc_j(32'h40));
        exp_ret(3, 32'h100); exp_ret(3, 32'h100);
        start();
        run(100);

        // $0 write discard, illegal opcode and unsupported funct as NOPs
        begin_section(0);
        mem[0] = 32'hAAAA_AAAA;
        lin(enc_i(OP_ADDI, 0, 0, 7), 4);
        lin({6'h3F, 5'd1, 5'd2, 16'h0010}, 2);
        lin(enc_r(FN_NOR, 10, 0, 0), 2);
        lin(enc_i(OP_SW, 0, 0, 0), 4);  exp_wr(32'd0, 32'd0);
        lin(enc_i(OP_SW, 2, 0, 4), 4);  exp_wr(32'd4, 32'd0);
        lin(enc_i(OP_SW, 10, 0, 8), 4); exp_wr(32'd8, 32'd0);
        start();
        run(200);

        // Reset during a stalled store
        begin_section(3);
        mem[1] = 32'h1234_5678;
        put_at(32'h100, enc_i(OP_ADDI, 1, 0, 9)); exp_ret(4, 32'h104);
        put_at(32'h104, enc_i(OP_SW, 1, 0, 4));
        start();
        run(100);
        for (int n = 0; n < 20 && !(memwrite && !memready); n++) tick();
        check("reach_memwr_wait", 32'(memwrite && !memready), 32'd1);
        reset = 1'b1;
        busy  = 1'b0;
        #1;
        check("mid_rst_memwrite", 32'(memwrite), 32'd0);
        check("mid_rst_retire", 32'(retire), 32'd0);
        check("mid_rst_pc", pc, RST_PC);
        check("mid_rst_memaddr", memaddr, RST_PC);
        tick();
        tick();
        check("no_store_on_reset", mem[1], 32'h1234_5678);
        put_at(32'h100, enc_i(OP_SW, 1, 0, 8)); exp_ret(7, 32'h104); exp_wr(32'd8, 32'd0);
        start();
        run(100);

        reset = 1'b1;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
